// File: rtl/object_datapath_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obj_pkg : shared geometry, op encodings and colours for object_datapath.
// Revision : 1.0
// ---------------------------------------------------------------------------
package obj_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int OBJ_W    = 25;
  localparam int OBJ_H    = 10;

  localparam logic [1:0] OP_DRAW  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;
  localparam logic [1:0] OP_ALT   = 2'b10;

  localparam logic [2:0] COLOUR_OBJ = 3'b111;
  localparam logic [2:0] COLOUR_ALT = 3'b100;
  localparam logic [2:0] COLOUR_BG  = 3'b000;

  // Both erase encodings (01 and 11) paint background.
  function automatic logic [2:0] op_colour(input logic [1:0] op,
                                           input logic [2:0] obj_c,
                                           input logic [2:0] alt_c,
                                           input logic [2:0] bg_c);
    logic [2:0] c;
    c = bg_c;
    case (op)
      OP_DRAW: c = obj_c;
      OP_ALT:  c = alt_c;
      default: c = bg_c;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/object_datapath_pixel_scan_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_scan_counter : col/row raster counter over an OBJ_W x OBJ_H box.
// Revision : 1.0
// ---------------------------------------------------------------------------
module pixel_scan_counter #(
  parameter int OBJ_W = 25,
  parameter int OBJ_H = 10,
  parameter int COL_W = $clog2(OBJ_W),
  parameter int ROW_W = $clog2(OBJ_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o
);

  localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(OBJ_W - 1);
  localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(OBJ_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Clear outranks enable so a position step always restarts the raster.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (col_q == c_COL_LAST) begin
        col_d = '0;
        row_d = (row_q == c_ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (col_q == c_COL_LAST) && (row_q == c_ROW_LAST);

endmodule
`default_nettype wire

// File: rtl/object_datapath.sv
`default_nettype none
// ---------------------------------------------------------------------------
// object_datapath : bouncing object position plus per-pixel raster output.
// Revision : 1.0
// ---------------------------------------------------------------------------
module object_datapath
  import obj_pkg::*;
#(
  parameter int         SCREEN_W   = obj_pkg::SCREEN_W,
  parameter int         SCREEN_H   = obj_pkg::SCREEN_H,
  parameter int         OBJ_W      = obj_pkg::OBJ_W,
  parameter int         OBJ_H      = obj_pkg::OBJ_H,
  parameter int         INIT_X     = 68,
  parameter int         INIT_Y     = 55,
  parameter int         STEP       = 1,
  parameter logic [2:0] OBJ_COLOUR = COLOUR_OBJ,
  parameter logic [2:0] ALT_COLOUR = COLOUR_ALT,
  parameter logic [2:0] BG_COLOUR  = COLOUR_BG
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_en,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       load_coord,
  input  logic       datapath_en,
  input  logic       plot,
  input  logic [1:0] op,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot_out,
  output logic       scan_done,
  output logic       edge_hit
);

  localparam int         COL_W   = $clog2(OBJ_W);
  localparam int         ROW_W   = $clog2(OBJ_H);
  localparam logic [8:0] c_X_MAX = 9'(SCREEN_W - OBJ_W);
  localparam logic [8:0] c_Y_MAX = 9'(SCREEN_H - OBJ_H);
  localparam logic [8:0] c_STEP  = 9'(STEP);

  logic [7:0] pos_x_q, pos_x_d;
  logic [6:0] pos_y_q, pos_y_d;
  logic       dx_q, dx_d, dy_q, dy_d, dx_pend_q, dx_pend_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d, done_q, done_d, edge_q, edge_d;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last;
  logic             capture;
  logic [8:0]       nx, ny;
  logic             bounce_x, bounce_y;

  // A position step takes priority over a scan advance in the same cycle.
  assign capture = datapath_en & ~load_coord;

  pixel_scan_counter #(
    .OBJ_W (OBJ_W),
    .OBJ_H (OBJ_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .en_i   (capture),
    .clr_i  (load_coord),
    .col_o  (col),
    .row_o  (row),
    .last_o (last)
  );

  // dx is a direction flag: 1 = positive. A bounce overrides any steering seen this cycle.
  always_comb begin
    dx_pend_d = dx_pend_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    nx        = {1'b0, pos_x_q};
    ny        = {2'b00, pos_y_q};
    bounce_x  = 1'b0;
    bounce_y  = 1'b0;
    if (move_en && (btn_left ^ btn_right)) begin
      dx_pend_d = btn_right;
    end
    if (load_coord) begin
      if (dx_pend_q) begin
        nx = {1'b0, pos_x_q} + c_STEP;
        if (nx > c_X_MAX) begin
          nx       = c_X_MAX;
          bounce_x = 1'b1;
        end
      end else if ({1'b0, pos_x_q} < c_STEP) begin
        nx       = '0;
        bounce_x = 1'b1;
      end else begin
        nx = {1'b0, pos_x_q} - c_STEP;
      end

      if (dy_q) begin
        ny = {2'b00, pos_y_q} + c_STEP;
        if (ny > c_Y_MAX) begin
          ny       = c_Y_MAX;
          bounce_y = 1'b1;
        end
      end else if ({2'b00, pos_y_q} < c_STEP) begin
        ny       = '0;
        bounce_y = 1'b1;
      end else begin
        ny = {2'b00, pos_y_q} - c_STEP;
      end

      dx_d    = dx_pend_q ^ bounce_x;
      dy_d    = dy_q ^ bounce_y;
      pos_x_d = nx[7:0];
      pos_y_d = ny[6:0];
      if (bounce_x) begin
        dx_pend_d = ~dx_pend_q;
      end
    end
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    edge_d   = load_coord & (bounce_x | bounce_y);
    if (capture) begin
      x_d      = pos_x_q + 8'(col);
      y_d      = pos_y_q + 7'(row);
      colour_d = op_colour(op, OBJ_COLOUR, ALT_COLOUR, BG_COLOUR);
      plot_d   = plot;
      done_d   = last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x_q   <= 8'(INIT_X);
      pos_y_q   <= 7'(INIT_Y);
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      dx_pend_q <= 1'b1;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      done_q    <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      dx_pend_q <= dx_pend_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      done_q    <= done_d;
      edge_q    <= edge_d;
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign colour    = colour_q;
  assign plot_out  = plot_q;
  assign scan_done = done_q;
  assign edge_hit  = edge_q;

endmodule
`default_nettype wire
